// File: rtl/uart_rx_byte_controller_pkg.sv
// Shared types and helpers for the UART receive byte controller.
// Build option: UART_RX_PARITY_EN enables the even-parity bit after data bit 7.
package uart_rx_byte_controller_pkg;

  typedef enum logic [2:0] {
    S_RX_IDLE   = 3'd0,
    S_RX_START  = 3'd1,
    S_RX_DATA   = 3'd2,
    S_RX_PARITY = 3'd3,
    S_RX_STOP   = 3'd4
  } UART_rx_state_type;

  function automatic logic even_parity(input logic [7:0] data);
    return ^data;
  endfunction

  function automatic logic [3:0] sat_inc4(input logic [3:0] value);
    return (value == 4'hF) ? value : value + 4'd1;
  endfunction

endpackage

// File: rtl/uart_rx_byte_controller_sync.sv
// Two-flop synchroniser for the asynchronous RX pin; both stages reset to idle-high.
module uart_rx_sync (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  // Two-stage capture of the asynchronous input
  always_ff @(posedge clk) begin
    if (reset) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx_byte_controller.sv
// 8N1 UART receiver with a one-entry holding register, overrun flag and framing error counter.
// Build option: UART_RX_PARITY_EN adds an even-parity bit and a sticky Parity_error flag.
module uart_rx_byte_controller
  import uart_rx_byte_controller_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434,
  parameter int HALF_BIT     = CLKS_PER_BIT / 2
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       Enable,
  input  logic       Unload_data,
  input  logic       UART_RX_I,
  output logic [7:0] RX_data,
  output logic       Empty,
  output logic       Overrun,
  output logic [3:0] Frame_error,
  output logic       Parity_error
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_BIT  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF_BIT - 1);

  UART_rx_state_type state, state_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic [2:0]        idx, idx_nxt;
  logic [7:0]        shift, shift_nxt;
  logic              rx_s;
  logic              stop_good, stop_bad, parity_bad;
  logic              commit_r;

  uart_rx_sync u_sync (
    .clk   (Clock),
    .reset (Reset),
    .d     (UART_RX_I),
    .q     (rx_s)
  );

  // Next-state, bit timer and shift register logic
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    idx_nxt    = idx;
    shift_nxt  = shift;
    stop_good  = 1'b0;
    stop_bad   = 1'b0;
    parity_bad = 1'b0;
    case (state)
      S_RX_IDLE: begin
        if (Enable && !rx_s) begin
          state_nxt = S_RX_START;
          cnt_nxt   = CNT_HALF;
        end else begin
          state_nxt = S_RX_IDLE;
        end
      end
      S_RX_START: begin
        if (cnt == '0) begin
          if (rx_s) begin
            state_nxt = S_RX_IDLE;
          end else begin
            state_nxt = S_RX_DATA;
            idx_nxt   = 3'd0;
            cnt_nxt   = CNT_BIT;
          end
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      S_RX_DATA: begin
        if (cnt == '0) begin
          shift_nxt = {rx_s, shift[7:1]};
          cnt_nxt   = CNT_BIT;
          if (idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_nxt = S_RX_PARITY;
`else
            state_nxt = S_RX_STOP;
`endif
          end else begin
            idx_nxt = idx + 3'd1;
          end
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
`ifdef UART_RX_PARITY_EN
      S_RX_PARITY: begin
        if (cnt == '0) begin
          parity_bad = (even_parity(shift) != rx_s);
          state_nxt  = S_RX_STOP;
          cnt_nxt    = CNT_BIT;
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
`endif
      S_RX_STOP: begin
        if (cnt == '0) begin
          // Back to idle at mid stop bit so the next start edge is not missed
          state_nxt = S_RX_IDLE;
          if (rx_s) begin
            stop_good = 1'b1;
          end else begin
            stop_bad = 1'b1;
          end
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      default: begin
        state_nxt = S_RX_IDLE;
      end
    endcase
  end

  // Receiver state register
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state <= S_RX_IDLE;
      cnt   <= '0;
      idx   <= 3'd0;
      shift <= 8'h00;
    end else if (!Enable) begin
      state <= S_RX_IDLE;
      cnt   <= '0;
      idx   <= 3'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      idx   <= idx_nxt;
      shift <= shift_nxt;
    end
  end

  // Holding register, handshake and error status
  always_ff @(posedge Clock) begin
    if (Reset) begin
      RX_data     <= 8'h00;
      Empty       <= 1'b1;
      Overrun     <= 1'b0;
      Frame_error <= 4'h0;
      commit_r    <= 1'b0;
    end else if (!Enable) begin
      Empty    <= 1'b1;
      Overrun  <= 1'b0;
      commit_r <= 1'b0;
    end else begin
      commit_r <= stop_good;
      if (stop_bad) begin
        Frame_error <= sat_inc4(Frame_error);
      end
      if (commit_r) begin
        RX_data <= shift;
        Empty   <= 1'b0;
        if (!Empty && !Unload_data) begin
          Overrun <= 1'b1;
        end
      end else if (Unload_data && !Empty) begin
        Empty <= 1'b1;
      end
    end
  end

`ifdef UART_RX_PARITY_EN
  // Sticky parity mismatch flag
  always_ff @(posedge Clock) begin
    if (Reset || !Enable) begin
      Parity_error <= 1'b0;
    end else if (parity_bad) begin
      Parity_error <= 1'b1;
    end
  end
`else
  assign Parity_error = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_byte_controller.sv
// Self-checking bench for uart_rx_byte_controller: directed frames plus randomized frames
// against a byte-level model. Honours UART_RX_PARITY_EN like the design.
module tb_uart_rx_byte_controller;

  localparam int CPB  = 16;
  localparam int HALF = CPB / 2;
`ifdef UART_RX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  // Cycles from start-edge drive until Empty is seen low: 2 sync flops, 1 idle detect,
  // half bit to start mid, NB-1 further bit periods to stop mid, 1 commit cycle.
  localparam int EXP_FALL = 2 + 1 + HALF + (NB - 1) * CPB + 1;

  logic       clk = 1'b0;
  logic       rst, en, unl, rx;
  logic [7:0] rx_data;
  logic       empty, ovr, perr;
  logic [3:0] ferr;

  int n_assert = 0;
  int n_fail   = 0;

  logic [7:0] m_data;
  logic       m_empty, m_ovr, m_perr;
  logic [3:0] m_ferr;

  logic [7:0] b;
  logic       stop_v, par_v;
  int         fall;

  always #5 clk = ~clk;

  uart_rx_byte_controller #(.CLKS_PER_BIT(CPB)) dut (
    .Clock        (clk),
    .Reset        (rst),
    .Enable       (en),
    .Unload_data  (unl),
    .UART_RX_I    (rx),
    .RX_data      (rx_data),
    .Empty        (empty),
    .Overrun      (ovr),
    .Frame_error  (ferr),
    .Parity_error (perr)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".RX_data"}, 32'(rx_data), 32'(m_data));
    chk({tag, ".Empty"}, 32'(empty), 32'(m_empty));
    chk({tag, ".Overrun"}, 32'(ovr), 32'(m_ovr));
    chk({tag, ".Frame_error"}, 32'(ferr), 32'(m_ferr));
    chk({tag, ".Parity_error"}, 32'(perr), 32'(m_perr));
  endtask

  // Drives one whole frame plus an idle tail; optional one-cycle Enable drop and Unload pulse.
  task automatic send(input logic [7:0] d, input logic stop, input logic par,
                      input int abort_at, input int unload_at, output int fall_idx);
    logic [10:0] fr;
    fr = 11'h7FF;
    fr[0] = 1'b0;
    fr[8:1] = d;
`ifdef UART_RX_PARITY_EN
    fr[9]  = par;
    fr[10] = stop;
`else
    fr[9] = stop;
`endif
    fall_idx = -1;
    for (int i = 0; i < NB * CPB + 16; i++) begin
      @(negedge clk);
      if (fall_idx < 0 && empty === 1'b0) fall_idx = i;
      rx  = (i < NB * CPB) ? fr[i / CPB] : 1'b1;
      en  = (i == abort_at) ? 1'b0 : 1'b1;
      unl = (i == unload_at) ? 1'b1 : 1'b0;
    end
  endtask

  task automatic frame_model(input logic [7:0] d, input logic stop, input logic par,
                             input logic same_unload);
`ifdef UART_RX_PARITY_EN
    if (par != ^d) m_perr = 1'b1;
`endif
    if (stop) begin
      if (!m_empty && !same_unload) m_ovr = 1'b1;
      m_data  = d;
      m_empty = 1'b0;
    end else if (m_ferr != 4'hF) begin
      m_ferr = m_ferr + 4'd1;
    end
  endtask

  task automatic unload_pulse();
    @(negedge clk);
    unl = 1'b1;
    @(negedge clk);
    unl = 1'b0;
    m_empty = 1'b1;
  endtask

  task automatic enable_pulse();
    @(negedge clk);
    en = 1'b0;
    @(negedge clk);
    en = 1'b1;
    m_empty = 1'b1;
    m_ovr   = 1'b0;
    m_perr  = 1'b0;
  endtask

  task automatic model_reset();
    m_data = 8'h00; m_empty = 1'b1; m_ovr = 1'b0; m_ferr = 4'h0; m_perr = 1'b0;
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; unl = 1'b0; rx = 1'b1;
    model_reset();
    repeat (3) @(negedge clk);
    check_all("reset");
    rst = 1'b0; en = 1'b1;
    repeat (4) @(negedge clk);

    // Basic frame with exact Empty timing, then unload
    send(8'h55, 1'b1, ^8'h55, -1, -1, fall);
    frame_model(8'h55, 1'b1, ^8'h55, 1'b0);
    chk("fall_0x55", 32'(fall), 32'(EXP_FALL));
    check_all("f55");
    unload_pulse();
    check_all("unload55");
    unload_pulse();
    check_all("unload_empty");

    // Bad stop bit
    send(8'hA3, 1'b0, ^8'hA3, -1, -1, fall);
    frame_model(8'hA3, 1'b0, ^8'hA3, 1'b0);
    check_all("badstopA3");

    // Short low glitch, then a valid frame
    @(negedge clk); rx = 1'b0;
    repeat (4) @(negedge clk);
    rx = 1'b1;
    repeat (30) @(negedge clk);
    check_all("glitch");
    send(8'hC7, 1'b1, ^8'hC7, -1, -1, fall);
    frame_model(8'hC7, 1'b1, ^8'hC7, 1'b0);
    check_all("fC7");

    // Enable drop mid data bit 3 flushes the held byte and the partial frame
    send(8'hFF, 1'b1, 1'b1, 4 * CPB + HALF, -1, fall);
    m_empty = 1'b1; m_ovr = 1'b0; m_perr = 1'b0;
    check_all("abortFF");
    send(8'h0F, 1'b1, ^8'h0F, -1, -1, fall);
    frame_model(8'h0F, 1'b1, ^8'h0F, 1'b0);
    check_all("f0F");
    unload_pulse();

    // Overrun, then flush with Enable low for one cycle
    send(8'h12, 1'b1, ^8'h12, -1, -1, fall);
    frame_model(8'h12, 1'b1, ^8'h12, 1'b0);
    send(8'h34, 1'b1, ^8'h34, -1, -1, fall);
    frame_model(8'h34, 1'b1, ^8'h34, 1'b0);
    check_all("overrun34");
    enable_pulse();
    check_all("flush");

    // Commit coinciding with unload: no overrun
    send(8'h5A, 1'b1, ^8'h5A, -1, -1, fall);
    frame_model(8'h5A, 1'b1, ^8'h5A, 1'b0);
    send(8'h6B, 1'b1, ^8'h6B, -1, EXP_FALL - 1, fall);
    frame_model(8'h6B, 1'b1, ^8'h6B, 1'b1);
    check_all("same_cycle");
    unload_pulse();

    // Randomized frames
    for (int k = 0; k < 24; k++) begin
      b      = 8'($urandom_range(0, 255));
      stop_v = ($urandom_range(0, 3) != 0);
      par_v  = ($urandom_range(0, 4) == 0) ? ~(^b) : ^b;
      repeat ($urandom_range(0, 20)) @(negedge clk);
      send(b, stop_v, par_v, -1, -1, fall);
      frame_model(b, stop_v, par_v, 1'b0);
      check_all("rand");
      if ($urandom_range(0, 1) == 1) unload_pulse();
      if (k % 8 == 7) enable_pulse();
    end

    // Framing error counter saturation
    for (int k = 0; k < 17; k++) begin
      send(8'($urandom_range(0, 255)), 1'b0, 1'b0, -1, -1, fall);
      frame_model(8'h00, 1'b0, 1'b0, 1'b0);
    end
    m_perr = perr;
`ifdef UART_RX_PARITY_EN
    enable_pulse();
`endif
    chk("ferr_sat", 32'(ferr), 32'h0000000F);
    check_all("sat");

`ifdef UART_RX_PARITY_EN
    enable_pulse();
    send(8'h03, 1'b1, 1'b0, -1, -1, fall);
    frame_model(8'h03, 1'b1, 1'b0, 1'b0);
    check_all("par03_ok");
    unload_pulse();
    send(8'h07, 1'b1, 1'b0, -1, -1, fall);
    frame_model(8'h07, 1'b1, 1'b0, 1'b0);
    check_all("par07_bad");
    unload_pulse();
    send(8'h03, 1'b1, 1'b0, -1, -1, fall);
    frame_model(8'h03, 1'b1, 1'b0, 1'b0);
    check_all("par03_sticky");
`endif

    // Reset in the middle of a frame
    send(8'h99, 1'b1, ^8'h99, -1, -1, fall);
    frame_model(8'h99, 1'b1, ^8'h99, 1'b0);
    @(negedge clk); rx = 1'b0;
    repeat (3 * CPB) @(negedge clk);
    rst = 1'b1; rx = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    repeat (12 * CPB) @(negedge clk);
    check_all("midreset");
    send(8'h81, 1'b1, ^8'h81, -1, -1, fall);
    frame_model(8'h81, 1'b1, ^8'h81, 1'b0);
    chk("fall_0x81", 32'(fall), 32'(EXP_FALL));
    check_all("f81");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
